// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master for the SafetyBoard link: frames {cmd, addr, data, chk}, captures the reply
// and issues idle sclk pulses with cs_n high so the slave re-arms its frame counters.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_PULSES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       req_bad_chk,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_rx_chk,
  output logic       rsp_chk_ok,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned GapW = (GAP_PULSES > 1) ? $clog2(GAP_PULSES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapMax = GapW'(GAP_PULSES - 1);

  // StDone is the single rsp_valid cycle between HOLD and GAP.
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StDone,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            half_q, half_d;
  logic [4:0]      bit_q, bit_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [31:0]     tx_q, tx_d;
  logic [15:0]     rx_q, rx_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [7:0]      rsp_rx_chk_q, rsp_rx_chk_d;
  logic            rsp_chk_ok_q, rsp_chk_ok_d;
  logic            tick;
  logic [7:0]      chk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StGap;
      cnt_q        <= '0;
      half_q       <= 1'b0;
      bit_q        <= '0;
      gap_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      rsp_data_q   <= '0;
      rsp_rx_chk_q <= '0;
      rsp_chk_ok_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_rx_chk_q <= rsp_rx_chk_d;
      rsp_chk_ok_q <= rsp_chk_ok_d;
    end
  end

  always_comb begin
    tick         = (cnt_q == CntMax);
    chk          = req_cmd ^ req_addr ^ req_data;
    state_d      = state_q;
    cnt_d        = tick ? '0 : cnt_q + CntW'(1);
    half_d       = half_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    rsp_data_d   = rsp_data_q;
    rsp_rx_chk_d = rsp_rx_chk_q;
    rsp_chk_ok_d = rsp_chk_ok_q;
    req_ready    = 1'b0;
    sclk         = 1'b0;
    cs_n         = 1'b1;
    mosi         = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        cnt_d     = '0;
        half_d    = 1'b0;
        if (req_valid) begin
          tx_d    = {req_cmd, req_addr, req_data, req_bad_chk ? ~chk : chk};
          cmd_d   = req_cmd;
          addr_d  = req_addr;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cs_n = 1'b0;
        mosi = tx_q[31];
        if (tick) begin
          state_d = StShift;
          bit_d   = '0;
          half_d  = 1'b0;
        end
      end
      StShift: begin
        cs_n = 1'b0;
        mosi = tx_q[31];
        sclk = half_q;
        if (tick) begin
          if (!half_q) begin
            // Sample on the same edge that raises sclk.
            half_d = 1'b1;
            rx_d   = {rx_q[14:0], miso};
          end else begin
            half_d = 1'b0;
            if (bit_q == 5'd31) begin
              state_d = StHold;
            end else begin
              bit_d = bit_q + 5'd1;
              tx_d  = {tx_q[30:0], 1'b0};
            end
          end
        end
      end
      StHold: begin
        cs_n = 1'b0;
        mosi = tx_q[31];
        if (tick) begin
          rsp_data_d   = rx_q[15:8];
          rsp_rx_chk_d = rx_q[7:0];
          rsp_chk_ok_d = (rx_q[7:0] == (cmd_q ^ addr_q ^ rx_q[15:8]));
          state_d      = StDone;
        end
      end
      StDone: begin
        cnt_d   = '0;
        half_d  = 1'b0;
        gap_d   = '0;
        state_d = StGap;
      end
      StGap: begin
        sclk = half_q;
        if (tick) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (gap_q == GapMax) begin
              state_d = StIdle;
            end else begin
              gap_d = gap_q + GapW'(1);
            end
          end
        end
      end
      default: begin
        state_d = StGap;
        cnt_d   = '0;
        half_d  = 1'b0;
        gap_d   = '0;
      end
    endcase
  end

  assign rsp_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign rsp_data   = rsp_data_q;
  assign rsp_rx_chk = rsp_rx_chk_q;
  assign rsp_chk_ok = rsp_chk_ok_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI mode-0 slave.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_cmd = 8'h00;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       req_bad_chk = 1'b0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] rsp_rx_chk;
  logic       rsp_chk_ok;
  logic       busy;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(
    .CLK_DIV   (4),
    .GAP_PULSES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_bad_chk(req_bad_chk),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_rx_chk (rsp_rx_chk),
    .rsp_chk_ok (rsp_chk_ok),
    .busy       (busy),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso)
  );

  // Slave: word to return, MSB first; bit k is presented after k falling edges of the frame.
  logic [31:0] slv_word = 32'h0;
  logic [31:0] mosi_word = 32'h0;
  int unsigned fall_cnt = 0;
  int unsigned base_fall = 0;
  int unsigned rise_cnt = 0;
  int unsigned gap_cnt = 0;
  int unsigned slv_idx;

  always @(negedge sclk) if (!cs_n) fall_cnt <= fall_cnt + 1;
  always @(negedge cs_n) base_fall <= fall_cnt;
  always @(posedge sclk) begin
    if (!cs_n) begin
      rise_cnt  <= rise_cnt + 1;
      mosi_word <= {mosi_word[30:0], mosi};
    end else begin
      gap_cnt <= gap_cnt + 1;
    end
  end
  always_comb begin
    slv_idx = fall_cnt - base_fall;
    miso    = 1'b0;
    if (!cs_n && slv_idx < 32) miso = slv_word[31 - slv_idx];
  end

  // Called at a negedge; returns after the rsp_valid cycle plus one.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                           input logic bad, output int lat, output logic [31:0] mw,
                           output logic [7:0] rd, output logic [7:0] rc, output logic ok,
                           output int rises, output logic vld_after);
    int n;
    int unsigned r0;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout: req_ready=%b after %0d cycles, want 1", req_ready, n);
    end
    req_cmd     = cmd;
    req_addr    = addr;
    req_data    = data;
    req_bad_chk = bad;
    req_valid   = 1'b1;
    r0          = rise_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 400);
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, lat);
    end
    mw    = mosi_word;
    rd    = rsp_data;
    rc    = rsp_rx_chk;
    ok    = rsp_chk_ok;
    rises = int'(rise_cnt - r0);
    @(negedge clk);
    vld_after = rsp_valid;
  endtask

  task automatic test_reset();
    int n;
    int unsigned g0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk, cs_n, mosi, rsp_valid, req_ready, busy} !== 6'b010001) begin
      failures++;
      $display("FAIL reset_ctrl: sclk,cs_n,mosi,rsp_valid,req_ready,busy=%b want 010001",
               {sclk, cs_n, mosi, rsp_valid, req_ready, busy});
    end
    checks++;
    if ({rsp_data, rsp_rx_chk, rsp_chk_ok} !== 17'h0) begin
      failures++;
      $display("FAIL reset_rsp: rsp_data=%h rsp_rx_chk=%h rsp_chk_ok=%b want 00 00 0",
               rsp_data, rsp_rx_chk, rsp_chk_ok);
    end
    g0  = gap_cnt;
    rst = 1'b0;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL reset_gap_len: ready after %0d cycles, want 16", n);
    end
    checks++;
    if (gap_cnt - g0 !== 2) begin
      failures++;
      $display("FAIL reset_gap_pulses: got %0d, want 2", gap_cnt - g0);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: busy=%b want 0", busy);
    end
  endtask

  task automatic test_write();
    int lat, rises;
    logic [31:0] mw;
    logic [7:0] rd, rc;
    logic ok, va;
    slv_word = 32'h0000_0004;
    run_frame(8'h01, 8'h05, 8'h01, 1'b0, lat, mw, rd, rc, ok, rises, va);
    checks++;
    if (mw !== 32'h0105_0105) begin
      failures++;
      $display("FAIL write_mosi: got %h want 01050105", mw);
    end
    checks++;
    if ({rd, rc, ok} !== {8'h00, 8'h04, 1'b1}) begin
      failures++;
      $display("FAIL write_rsp: data=%h chk=%h ok=%b want 00 04 1", rd, rc, ok);
    end
    checks++;
    if (lat !== 265) begin
      failures++;
      $display("FAIL write_latency: got %0d want 265", lat);
    end
    checks++;
    if (va !== 1'b0) begin
      failures++;
      $display("FAIL write_pulse: rsp_valid=%b one cycle later, want 0", va);
    end
  endtask

  task automatic test_read(input logic [7:0] rchk, input logic exp_ok, input string name);
    int lat, rises;
    logic [31:0] mw;
    logic [7:0] rd, rc;
    logic ok, va;
    slv_word = {16'h0000, 8'h03, rchk};
    run_frame(8'h81, 8'h02, 8'h00, 1'b0, lat, mw, rd, rc, ok, rises, va);
    checks++;
    if (mw !== 32'h8102_0083) begin
      failures++;
      $display("FAIL %s_mosi: got %h want 81020083", name, mw);
    end
    checks++;
    if ({rd, rc, ok} !== {8'h03, rchk, exp_ok}) begin
      failures++;
      $display("FAIL %s_rsp: data=%h chk=%h ok=%b want 03 %h %b", name, rd, rc, ok, rchk, exp_ok);
    end
    checks++;
    if (rises !== 32) begin
      failures++;
      $display("FAIL %s_rises: got %0d want 32", name, rises);
    end
  endtask

  task automatic test_fault();
    int lat, rises;
    logic [31:0] mw;
    logic [7:0] rd, rc;
    logic ok, va;
    slv_word = 32'h0000_0004;
    run_frame(8'h01, 8'h05, 8'h01, 1'b1, lat, mw, rd, rc, ok, rises, va);
    req_bad_chk = 1'b0;
    checks++;
    if (mw !== 32'h0105_01FA) begin
      failures++;
      $display("FAIL fault_mosi: got %h want 010501fa", mw);
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL fault_ok: got %b want 1", ok);
    end
  endtask

  task automatic test_back_to_back();
    int n, m, early;
    int unsigned g0, r0;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    slv_word  = 32'h0000_0004;
    req_cmd   = 8'h01;
    req_addr  = 8'h05;
    req_data  = 8'h01;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_cmd  = 8'h81;
    req_addr = 8'h02;
    req_data = 8'h00;
    n        = 0;
    early    = 0;
    do begin
      @(negedge clk);
      n++;
      if (req_ready) early++;
    end while (!rsp_valid && n < 400);
    checks++;
    if (n !== 265 || early !== 0) begin
      failures++;
      $display("FAIL b2b_first: rsp at %0d ready_cycles=%0d, want 265 0", n, early);
    end
    checks++;
    if ({rsp_data, rsp_rx_chk, rsp_chk_ok} !== {8'h00, 8'h04, 1'b1}) begin
      failures++;
      $display("FAIL b2b_rsp1: data=%h chk=%h ok=%b want 00 04 1",
               rsp_data, rsp_rx_chk, rsp_chk_ok);
    end
    slv_word = 32'h0000_0380;
    g0       = gap_cnt;
    m        = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!req_ready && m < 100);
    checks++;
    if (m !== 17) begin
      failures++;
      $display("FAIL b2b_gap_len: ready %0d cycles after rsp_valid, want 17", m);
    end
    checks++;
    if (gap_cnt - g0 !== 2) begin
      failures++;
      $display("FAIL b2b_gap_pulses: got %0d want 2", gap_cnt - g0);
    end
    checks++;
    if (rsp_data !== 8'h00 || rsp_rx_chk !== 8'h04) begin
      failures++;
      $display("FAIL b2b_hold: data=%h chk=%h want 00 04", rsp_data, rsp_rx_chk);
    end
    r0 = rise_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 400);
    checks++;
    if (n !== 265) begin
      failures++;
      $display("FAIL b2b_second_latency: got %0d want 265", n);
    end
    checks++;
    if ({mosi_word, rsp_data, rsp_rx_chk, rsp_chk_ok} !== {32'h8102_0083, 8'h03, 8'h80, 1'b1}) begin
      failures++;
      $display("FAIL b2b_rsp2: mosi=%h data=%h chk=%h ok=%b want 81020083 03 80 1",
               mosi_word, rsp_data, rsp_rx_chk, rsp_chk_ok);
    end
    checks++;
    if (rise_cnt - r0 !== 32) begin
      failures++;
      $display("FAIL b2b_rises: got %0d want 32", rise_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    int n, vseen, lat, rises;
    int unsigned r0, g0;
    logic [31:0] mw;
    logic [7:0] rd, rc;
    logic ok, va;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    slv_word  = 32'h0000_0004;
    req_cmd   = 8'h01;
    req_addr  = 8'h05;
    req_data  = 8'h01;
    req_valid = 1'b1;
    r0        = rise_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (rise_cnt - r0 < 13 && n < 400) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({cs_n, sclk, mosi, rsp_valid, req_ready} !== 5'b10000) begin
      failures++;
      $display("FAIL midreset_out: cs_n,sclk,mosi,rsp_valid,req_ready=%b want 10000",
               {cs_n, sclk, mosi, rsp_valid, req_ready});
    end
    checks++;
    if (rise_cnt - r0 !== 13) begin
      failures++;
      $display("FAIL midreset_rises: got %0d want 13", rise_cnt - r0);
    end
    g0    = gap_cnt;
    vseen = 0;
    n     = 0;
    do begin
      @(negedge clk);
      n++;
      if (rsp_valid) vseen++;
    end while (!req_ready && n < 100);
    checks++;
    if (vseen !== 0 || gap_cnt - g0 !== 2) begin
      failures++;
      $display("FAIL midreset_gap: rsp_valid_cycles=%0d gap_pulses=%0d want 0 2",
               vseen, gap_cnt - g0);
    end
    slv_word = 32'h0000_0380;
    run_frame(8'h81, 8'h02, 8'h00, 1'b0, lat, mw, rd, rc, ok, rises, va);
    checks++;
    if ({mw, rd, rc, ok} !== {32'h8102_0083, 8'h03, 8'h80, 1'b1} || lat !== 265) begin
      failures++;
      $display("FAIL midreset_next: mosi=%h data=%h chk=%h ok=%b lat=%0d want 81020083 03 80 1 265",
               mw, rd, rc, ok, lat);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read(8'h80, 1'b1, "read");
    test_read(8'h81, 1'b0, "corrupt");
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
